// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch unit.
// Walks BOOT -> AR -> R -> WAIT, issuing one AXI read per instruction and
// handing the selected 32-bit word to decode as a one-cycle pulse.
// Optional feature macro: IFU_MISALIGN_CHK_EN. When defined, a misaligned
// redirect target raises a sticky ifetch_misalign flag and parks the unit
// in HALT. When undefined, redirect targets are word-aligned by clearing
// bits [1:0].
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifetch_req,
  input  logic        ifetch_taken,
  input  logic [63:0] ifetch_taken_pc,
  output logic [63:0] axi_AR_ADDR,
  output logic        axi_AR_VALID,
  input  logic        axi_AR_READY,
  input  logic [63:0] axi_R_DATA,
  input  logic        axi_R_VALID,
  output logic        axi_R_READY,
  output logic        dec_inst_vld,
  output logic [63:0] dec_inst_pc,
  output logic [31:0] dec_inst
`ifdef IFU_MISALIGN_CHK_EN
  ,
  output logic        ifetch_misalign
`endif
);

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_WAIT = 3'd3
`ifdef IFU_MISALIGN_CHK_EN
    ,
    S_HALT = 3'd4
`endif
  } state_t;

  state_t      state_reg, state_next;
  logic [63:0] pc_reg, pc_next;
  logic [31:0] inst_reg, inst_next;
  logic [63:0] inst_pc_reg, inst_pc_next;
  logic        vld_reg, vld_next;
  logic [63:0] seq_pc;
  logic [63:0] redirect_pc;
  logic        redirect_bad;
  logic [31:0] lane_word [2];

  // The 64-bit read beat carries two instruction words; pc[2] picks the lane.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign lane_word[gi] = axi_R_DATA[32*gi +: 32];
  end

  // Sequential successor wraps naturally at 2^64.
  assign seq_pc = pc_reg + 64'd4;

`ifdef IFU_MISALIGN_CHK_EN
  logic misalign_reg, misalign_next;

  assign redirect_pc     = ifetch_taken_pc;
  assign redirect_bad    = |ifetch_taken_pc[1:0];
  assign ifetch_misalign = misalign_reg;
`else
  // Without the checker, a misaligned target is silently word-aligned.
  assign redirect_pc  = ifetch_taken_pc & ~64'h3;
  assign redirect_bad = 1'b0;
`endif

  // State register and datapath registers; reset abandons any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_BOOT;
      pc_reg       <= RESET_PC;
      inst_reg     <= 32'h0;
      inst_pc_reg  <= RESET_PC;
      vld_reg      <= 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
      misalign_reg <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      inst_reg     <= inst_next;
      inst_pc_reg  <= inst_pc_next;
      vld_reg      <= vld_next;
`ifdef IFU_MISALIGN_CHK_EN
      misalign_reg <= misalign_next;
`endif
    end
  end

  // Next-state, next-datapath and AXI handshake outputs.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    inst_next     = inst_reg;
    inst_pc_next  = inst_pc_reg;
    vld_next      = 1'b0;
    axi_AR_VALID  = 1'b0;
    axi_R_READY   = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
    misalign_next = misalign_reg;
`endif
    case (state_reg)
      S_BOOT: begin
        // pc already holds RESET_PC from reset.
        state_next = S_AR;
      end
      S_AR: begin
        // Address and valid come straight from state/pc, so they stay
        // stable until the slave accepts. R_VALID is not looked at here.
        axi_AR_VALID = 1'b1;
        if (axi_AR_READY) begin
          state_next = S_R;
        end
      end
      S_R: begin
        axi_R_READY = 1'b1;
        if (axi_R_VALID) begin
          inst_next    = lane_word[pc_reg[2]];
          inst_pc_next = pc_reg;
          vld_next     = 1'b1;
          state_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ifetch_req) begin
          if (ifetch_taken) begin
            if (redirect_bad) begin
`ifdef IFU_MISALIGN_CHK_EN
              misalign_next = 1'b1;
              state_next    = S_HALT;
`endif
            end else begin
              pc_next    = redirect_pc;
              state_next = S_AR;
            end
          end else begin
            pc_next    = seq_pc;
            state_next = S_AR;
          end
        end
      end
`ifdef IFU_MISALIGN_CHK_EN
      S_HALT: begin
        // Parked until reset; no further reads are issued.
        state_next = S_HALT;
      end
`endif
      default: begin
        state_next = S_BOOT;
      end
    endcase
  end

  assign axi_AR_ADDR  = pc_reg;
  assign dec_inst_vld = vld_reg;
  assign dec_inst     = inst_reg;
  assign dec_inst_pc  = inst_pc_reg;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: table-driven directed vectors, a reset-in-R sequence,
// randomized fetch streams against a PC/instruction reference model, and a
// final misaligned redirect (checked according to IFU_MISALIGN_CHK_EN).
module tb_ifu_fetch;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifetch_req = 1'b0;
  logic        ifetch_taken = 1'b0;
  logic [63:0] ifetch_taken_pc = '0;
  logic [63:0] axi_AR_ADDR;
  logic        axi_AR_VALID;
  logic        axi_AR_READY = 1'b0;
  logic [63:0] axi_R_DATA = '0;
  logic        axi_R_VALID = 1'b0;
  logic        axi_R_READY;
  logic        dec_inst_vld;
  logic [63:0] dec_inst_pc;
  logic [31:0] dec_inst;
`ifdef IFU_MISALIGN_CHK_EN
  logic        ifetch_misalign;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .ifetch_req      (ifetch_req),
    .ifetch_taken    (ifetch_taken),
    .ifetch_taken_pc (ifetch_taken_pc),
    .axi_AR_ADDR     (axi_AR_ADDR),
    .axi_AR_VALID    (axi_AR_VALID),
    .axi_AR_READY    (axi_AR_READY),
    .axi_R_DATA      (axi_R_DATA),
    .axi_R_VALID     (axi_R_VALID),
    .axi_R_READY     (axi_R_READY),
    .dec_inst_vld    (dec_inst_vld),
    .dec_inst_pc     (dec_inst_pc),
    .dec_inst        (dec_inst)
`ifdef IFU_MISALIGN_CHK_EN
    ,
    .ifetch_misalign (ifetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ar_wait;
    int          r_wait;
    logic [63:0] rdata;
    logic [63:0] exp_addr;
    logic [31:0] exp_inst;
    bit          taken;
    logic [63:0] tpc;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete AR + R transaction; called at a negedge with the unit in or
  // about to enter AR. Returns at the negedge one cycle after the vld pulse.
  task automatic do_fetch(input string tag, input int ar_wait, input int r_wait,
                          input bit noise, input logic [63:0] rdata,
                          input logic [63:0] exp_addr, input logic [31:0] exp_inst);
    int cyc = 0;
    while (axi_AR_VALID !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " ar_valid_seen"}, (cyc < 50) ? 64'd1 : 64'd0, 64'd1);
    if (cyc >= 50) return;
    chk({tag, " ar_addr"}, axi_AR_ADDR, exp_addr);
    for (int i = 0; i < ar_wait; i++) begin
      if (noise) begin
        ifetch_req      = 1'($urandom_range(0, 1));
        ifetch_taken    = 1'($urandom_range(0, 1));
        ifetch_taken_pc = {$urandom, $urandom};
        axi_R_VALID     = 1'($urandom_range(0, 1));
        axi_R_DATA      = {$urandom, $urandom};
      end
      @(negedge clk);
      chk({tag, " ar_valid_hold"}, axi_AR_VALID, 1'b1);
      chk({tag, " ar_addr_hold"}, axi_AR_ADDR, exp_addr);
    end
    axi_AR_READY = 1'b1;
    if (noise) begin
      axi_R_VALID = 1'b1;
      axi_R_DATA  = ~rdata;
    end
    @(negedge clk);
    axi_AR_READY = 1'b0;
    axi_R_VALID  = 1'b0;
    ifetch_req   = 1'b0;
    ifetch_taken = 1'b0;
    chk({tag, " r_ready"}, axi_R_READY, 1'b1);
    chk({tag, " ar_valid_drop"}, axi_AR_VALID, 1'b0);
    chk({tag, " no_early_vld"}, dec_inst_vld, 1'b0);
    for (int i = 0; i < r_wait; i++) begin
      if (noise) begin
        ifetch_req      = 1'($urandom_range(0, 1));
        ifetch_taken    = 1'($urandom_range(0, 1));
        ifetch_taken_pc = {$urandom, $urandom};
        axi_AR_READY    = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      chk({tag, " r_wait_no_vld"}, dec_inst_vld, 1'b0);
    end
    ifetch_req   = 1'b0;
    ifetch_taken = 1'b0;
    axi_AR_READY = 1'b0;
    axi_R_VALID  = 1'b1;
    axi_R_DATA   = rdata;
    @(negedge clk);
    axi_R_VALID = 1'b0;
    axi_R_DATA  = {$urandom, $urandom};
    chk({tag, " vld_pulse"}, dec_inst_vld, 1'b1);
    chk({tag, " dec_inst"}, dec_inst, exp_inst);
    chk({tag, " dec_inst_pc"}, dec_inst_pc, exp_addr);
    chk({tag, " r_ready_drop"}, axi_R_READY, 1'b0);
    @(negedge clk);
    chk({tag, " vld_one_cycle"}, dec_inst_vld, 1'b0);
    chk({tag, " dec_inst_hold"}, dec_inst, exp_inst);
    $display("txn %0d %s addr=%h inst=%h pc=%h", n_txn, tag, exp_addr, dec_inst, dec_inst_pc);
    n_txn++;
  endtask

  // Sit in WAIT for 'delay' cycles (optionally with stray AXI inputs), then
  // pulse ifetch_req for one cycle.
  task automatic issue_req(input int delay, input bit taken, input logic [63:0] tpc,
                           input bit noise, input bit expect_ar);
    for (int i = 0; i < delay; i++) begin
      if (noise) begin
        axi_R_VALID  = 1'($urandom_range(0, 1));
        axi_R_DATA   = {$urandom, $urandom};
        axi_AR_READY = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      chk("wait_no_vld", dec_inst_vld, 1'b0);
      chk("wait_no_ar", axi_AR_VALID, 1'b0);
    end
    axi_R_VALID     = 1'b0;
    axi_AR_READY    = 1'b0;
    ifetch_req      = 1'b1;
    ifetch_taken    = taken;
    ifetch_taken_pc = tpc;
    @(negedge clk);
    ifetch_req   = 1'b0;
    ifetch_taken = 1'b0;
    chk("ar_after_req", axi_AR_VALID, expect_ar);
  endtask

  initial begin
    logic [63:0] exp_pc;
    logic [63:0] data;
    logic [63:0] tpc;
    logic [31:0] exp_inst;
    bit          taken;

    vecs[0] = '{0, 2, 64'h1111_2222_0000_0013, 64'h0000_0000_8000_0000, 32'h0000_0013, 1'b0, 64'h0};
    vecs[1] = '{0, 0, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0000_0000_8000_0004, 32'hAAAA_BBBB, 1'b1, 64'h0000_0000_8000_0100};
    vecs[2] = '{5, 1, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_8000_0100, 32'h9ABC_DEF0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[3] = '{1, 3, 64'h0BAD_F00D_DEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0BAD_F00D, 1'b0, 64'h0};
    vecs[4] = '{2, 0, 64'h5555_6666_7777_8888, 64'h0000_0000_0000_0000, 32'h7777_8888, 1'b0, 64'h0};

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst ar_valid", axi_AR_VALID, 1'b0);
    chk("rst r_ready", axi_R_READY, 1'b0);
    chk("rst vld", dec_inst_vld, 1'b0);
    chk("rst dec_inst", dec_inst, 32'h0);
    chk("rst dec_inst_pc", dec_inst_pc, RESET_PC);
    chk("rst ar_addr", axi_AR_ADDR, RESET_PC);
`ifdef IFU_MISALIGN_CHK_EN
    chk("rst misalign", ifetch_misalign, 1'b0);
`endif
    rst = 1'b0;

    // Directed table.
    for (int v = 0; v < 5; v++) begin
      do_fetch("vec", vecs[v].ar_wait, vecs[v].r_wait, 1'b0, vecs[v].rdata,
               vecs[v].exp_addr, vecs[v].exp_inst);
      issue_req(0, vecs[v].taken, vecs[v].tpc, 1'b0, 1'b1);
    end

    // Reset while in R, with a stray ifetch_req pulse during R.
    chk("rstR ar_addr", axi_AR_ADDR, 64'h4);
    axi_AR_READY = 1'b1;
    @(negedge clk);
    axi_AR_READY    = 1'b0;
    ifetch_req      = 1'b1;
    ifetch_taken    = 1'b1;
    ifetch_taken_pc = 64'h0000_0000_1234_0000;
    @(negedge clk);
    ifetch_req   = 1'b0;
    ifetch_taken = 1'b0;
    chk("rstR still_in_r", axi_R_READY, 1'b1);
    rst         = 1'b1;
    axi_R_VALID = 1'b1;
    axi_R_DATA  = 64'hDEAD_DEAD_DEAD_DEAD;
    #1;
    chk("rstR ar_valid", axi_AR_VALID, 1'b0);
    chk("rstR r_ready", axi_R_READY, 1'b0);
    chk("rstR ar_addr_reset", axi_AR_ADDR, RESET_PC);
    chk("rstR dec_inst", dec_inst, 32'h0);
    chk("rstR dec_inst_pc", dec_inst_pc, RESET_PC);
    chk("rstR vld", dec_inst_vld, 1'b0);
    @(negedge clk);
    chk("rstR vld_held", dec_inst_vld, 1'b0);
    axi_R_VALID = 1'b0;
    rst         = 1'b0;
    exp_pc = RESET_PC;
    data   = 64'h0000_00AA_0000_0BB3;
    do_fetch("after_rst", 0, 1, 1'b0, data, exp_pc, data[31:0]);

    // Randomized stream against the PC/instruction model.
    for (int t = 0; t < 30; t++) begin
      taken = 1'($urandom_range(0, 1));
      tpc   = {$urandom, $urandom};
`ifdef IFU_MISALIGN_CHK_EN
      tpc[1:0] = 2'b00;
`endif
      issue_req($urandom_range(0, 2), taken, tpc, 1'b1, 1'b1);
      exp_pc   = taken ? {tpc[63:2], 2'b00} : exp_pc + 64'd4;
      data     = {$urandom, $urandom};
      exp_inst = exp_pc[2] ? data[63:32] : data[31:0];
      do_fetch("rand", $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, data, exp_pc, exp_inst);
    end

    // Misaligned redirect target.
`ifdef IFU_MISALIGN_CHK_EN
    issue_req(1, 1'b1, 64'h0000_0000_8000_0102, 1'b0, 1'b0);
    chk("misalign set", ifetch_misalign, 1'b1);
    for (int i = 0; i < 20; i++) begin
      ifetch_req   = 1'($urandom_range(0, 1));
      ifetch_taken = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("halt no_ar", axi_AR_VALID, 1'b0);
      chk("halt misalign_sticky", ifetch_misalign, 1'b1);
    end
    ifetch_req = 1'b0;
`else
    issue_req(1, 1'b1, 64'h0000_0000_8000_0102, 1'b0, 1'b1);
    data = 64'h7777_0000_3333_0001;
    do_fetch("align", 0, 0, 1'b0, data, 64'h0000_0000_8000_0100, 32'h3333_0001);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL provide parameter: RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port: ifetch_req  input  1  execute stage finished current instruction; fetch next.
REQ-005 SHALL provide port: ifetch_taken  input  1  qualifies ifetch_req as redirect.
REQ-006 SHALL provide port: ifetch_taken_pc  input  64  redirect target.
REQ-007 SHALL provide ports: axi_AR_ADDR output 64, axi_AR_VALID output 1, axi_AR_READY input 1  read-address channel.
REQ-008 SHALL provide ports: axi_R_DATA input 64, axi_R_VALID input 1, axi_R_READY output 1  read-data channel.
REQ-009 SHALL provide port: dec_inst_vld  output 1  one-cycle pulse, new instruction available.
REQ-010 SHALL provide ports: dec_inst_pc output 64, dec_inst output 32  fetched PC and instruction word.

Function
REQ-011 SHALL implement FSM states BOOT, AR, R, WAIT (plus HALT per REQ-024); one instruction in flight at a time.
REQ-012 SHALL leave BOOT for AR on the first clock edge after rst deasserts, with pc = RESET_PC.
REQ-013 In AR, SHALL drive axi_AR_VALID=1 and axi_AR_ADDR=pc, both stable until axi_AR_READY; handshake cycle -> R.
REQ-014 In R, SHALL drive axi_R_READY=1; on axi_R_VALID -> WAIT; axi_R_READY=0 in all other states.
REQ-015 On R handshake, SHALL register dec_inst = pc[2] ? axi_R_DATA[63:32] : axi_R_DATA[31:0] and dec_inst_pc = pc; dec_inst_vld=1 for exactly the next cycle.
REQ-016 SHALL hold dec_inst and dec_inst_pc stable from capture until the next capture.
REQ-017 In WAIT, on ifetch_req: pc <= ifetch_taken ? ifetch_taken_pc : pc+4; -> AR; axi_AR_VALID asserts the following cycle.
REQ-018 pc+4 SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 0).
REQ-019 SHALL ignore ifetch_req, ifetch_taken, and ifetch_taken_pc in BOOT, AR, R, and HALT.
REQ-020 SHALL ignore axi_R_VALID outside R and axi_AR_READY outside AR.
REQ-021 AR_READY and R_VALID in the same cycle: SHALL complete AR only; R data accepted no earlier than the next cycle.

Reset
REQ-022 While rst=1: state=BOOT, pc=RESET_PC, axi_AR_VALID=0, axi_R_READY=0, dec_inst_vld=0, dec_inst=32'h0, dec_inst_pc=RESET_PC, axi_AR_ADDR=RESET_PC.
REQ-023 rst asserted mid-transaction (AR or R) SHALL abandon the transaction immediately, with no dec_inst_vld; fetching SHALL restart at RESET_PC.

Configuration
REQ-024 Macro IFU_MISALIGN_CHK_EN defined: SHALL add output ifetch_misalign (1 bit, reset 0); a WAIT redirect with ifetch_taken_pc[1:0]!=0 SHALL set ifetch_misalign sticky until reset, enter HALT, and issue no further AR.
REQ-025 Macro undefined: no ifetch_misalign port and no HALT state; redirect target SHALL be used with bits [1:0] forced to 0.

Verification
REQ-026 Reset release, AR_READY=1, R_VALID 2 cycles later with data 64'h1111_2222_0000_0013 -> AR_ADDR=0x8000_0000; dec_inst=0x0000_0013, dec_inst_pc=0x8000_0000; dec_inst_vld high 1 cycle.
REQ-027 ifetch_req=1, ifetch_taken=0 in WAIT at pc 0x8000_0000 -> next AR_ADDR=0x8000_0004; dec_inst = upper word of R_DATA.
REQ-028 ifetch_req with ifetch_taken=1, ifetch_taken_pc=0x8000_0100; AR_READY held low 5 cycles -> AR_VALID high 6 cycles with AR_ADDR constant 0x8000_0100.
REQ-029 rst pulse while in R -> no dec_inst_vld; next AR_ADDR=0x8000_0000; ifetch_req pulsed during R is ignored.
REQ-030 With IFU_MISALIGN_CHK_EN, redirect to 0x8000_0102 -> ifetch_misalign=1, no AR_VALID for 20 cycles. Without the macro, the same redirect -> AR_ADDR=0x8000_0100.
